// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the block sum accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_accumulator_pkg;

    // Block FSM states: waiting for a first sample, summing, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Accumulator width that holds 2^cnt_w samples of (n+1) bits without wrapping.
    function automatic int acc_width(input int n, input int cnt_w);
        return n + 1 + cnt_w;
    endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Sums a programmable-length block of {carry, sum} adder samples and tracks the block peak.
// Latency: out_valid rises on the edge after the last sample transfer.
// Backpressure: in_ready low while a result waits; one bubble cycle separates blocks.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int N          = 8,
    parameter int CNT_W      = 8,
    localparam int ACC_W     = acc_width(N, CNT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             carry_in,
    input  logic [N-1:0]     sum_in,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [N:0]       peak_out,
    output logic             busy
);

    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);
    // count==0 encodes a full block of 2^CNT_W samples.
    localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [N:0]       peak_q,  peak_d;
    logic [CNT_W:0]   cnt_q,   cnt_d;
    logic [CNT_W:0]   tgt_q,   tgt_d;

    logic [N:0]       sample;
    logic [ACC_W-1:0] sample_ext;
    logic [CNT_W:0]   tgt_new;
    logic [CNT_W:0]   cnt_inc;
    logic             xfer;

    assign sample     = {carry_in, sum_in};
    assign sample_ext = ACC_W'(sample);
    assign tgt_new    = (count == '0) ? CNT_FULL : {1'b0, count};
    assign cnt_inc    = cnt_q + CNT_ONE;
    assign xfer       = in_valid && in_ready;

    // State register; reset abandons any block in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear wins over any transfer or handshake.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = (tgt_new == CNT_ONE) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer && (cnt_inc == tgt_q)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded purely from the state register.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE:    busy = 1'b0;
            ACCUM:   ;
            DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath next-state: first sample seeds the block, later ones accumulate.
    always_comb begin
        acc_d  = acc_q;
        peak_d = peak_q;
        cnt_d  = cnt_q;
        tgt_d  = tgt_q;
        if (clear) begin
            acc_d  = '0;
            peak_d = '0;
            cnt_d  = '0;
            tgt_d  = '0;
        end else if (xfer) begin
            if (state_q == IDLE) begin
                acc_d  = sample_ext;
                peak_d = sample;
                cnt_d  = CNT_ONE;
                tgt_d  = tgt_new;
            end else begin
                acc_d  = acc_q + sample_ext;
                peak_d = (sample > peak_q) ? sample : peak_q;
                cnt_d  = cnt_inc;
            end
        end
    end

    // Datapath registers; results hold after handoff until the next block starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            peak_q <= '0;
            cnt_q  <= '0;
            tgt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
        end
    end

    assign acc_out  = acc_q;
    assign peak_out = peak_q;

endmodule
